quan_mult_p_vecop_unpack: RTL and testbench

Result-side counterpart of the multiplier-array operand packer. Accepts the product vector from the external multiplier array (64 lanes × `mult_P_width`), applies each channel's rescale right shift with round-half-up, saturates every lane to int8, and hands quantized pixel vectors downstream over a valid/ready interface. Mode 0 (8×8) products form one output beat. Mode 1 (1×8, two weight channels) forms two beats, channel 0 then channel 1, so a single 32-lane quantizer array is shared between the channels.

---
 rtl/quan_pkg.sv | 24 ++
 rtl/quan_lane_round_sat.sv | 36 +++
 rtl/quan_mult_p_vecop_unpack.sv | 108 ++++++++++
 tb/tb_quan_mult_p_vecop_unpack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/quan_pkg.sv
// rtl/quan_pkg.sv - shared widths, mode encodings and FSM states for the product unpacker
package quan_pkg;

  localparam int COLUMN_NUM_IN_SA   = 16;
  localparam int PE_PARALLEL_PIXEL  = 2;
  localparam int PE_PARALLEL_WEIGHT = 2;
  localparam int MULT_P_WIDTH       = 40;
  localparam int SHIFT_WIDTH        = 6;
  localparam int OUT_WIDTH          = 8;
  localparam int L                  = PE_PARALLEL_PIXEL * COLUMN_NUM_IN_SA;
  localparam int NUM_LANES          = L * PE_PARALLEL_WEIGHT;

  localparam logic [3:0] MODE_88 = 4'd0;
  localparam logic [3:0] MODE_18 = 4'd1;

  localparam logic [SHIFT_WIDTH-1:0] SHIFT_CLAMP = SHIFT_WIDTH'(MULT_P_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/quan_lane_round_sat.sv
// rtl/quan_lane_round_sat.sv - one-lane arithmetic right shift with round-half-up and int8 saturation
module quan_lane_round_sat
  import quan_pkg::*;
(
  input  logic [MULT_P_WIDTH-1:0] i_p,
  input  logic [SHIFT_WIDTH-1:0]  i_shift,
  output logic [OUT_WIDTH-1:0]    o_q
);

  localparam logic signed [MULT_P_WIDTH:0] ONE     = {{MULT_P_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [MULT_P_WIDTH:0] SAT_MAX = 41'sd127;
  localparam logic signed [MULT_P_WIDTH:0] SAT_MIN = -41'sd128;

  logic [SHIFT_WIDTH-1:0]         w_s;
  logic signed [MULT_P_WIDTH:0]   w_p;
  logic signed [MULT_P_WIDTH:0]   w_bias;
  logic signed [MULT_P_WIDTH:0]   w_sum;
  logic signed [MULT_P_WIDTH:0]   w_r;

  assign w_s    = (i_shift > SHIFT_CLAMP) ? SHIFT_CLAMP : i_shift;
  assign w_p    = {i_p[MULT_P_WIDTH-1], i_p};
  // One extra bit of headroom keeps p + 2^(s-1) from wrapping for any 40-bit p.
  assign w_bias = (w_s == '0) ? '0 : (ONE <<< (w_s - 1'b1));
  assign w_sum  = w_p + w_bias;
  assign w_r    = w_sum >>> w_s;

  always_comb begin
    o_q = w_r[OUT_WIDTH-1:0];
    if (w_r > SAT_MAX) begin
      o_q = 8'h7F;
    end else if (w_r < SAT_MIN) begin
      o_q = 8'h80;
    end
  end

endmodule

// File: rtl/quan_mult_p_vecop_unpack.sv
// rtl/quan_mult_p_vecop_unpack.sv - quantizes the multiplier product vector into int8 output beats
module quan_mult_p_vecop_unpack
  import quan_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [3:0]                      mode,
  input  logic [2*SHIFT_WIDTH-1:0]        shift_set,
  input  logic [NUM_LANES*MULT_P_WIDTH-1:0] P_vector,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [L*OUT_WIDTH-1:0]          out_vector,
  output logic                            out_channel,
  output logic                            out_last
);

  state_t                            r_state;
  logic [NUM_LANES*MULT_P_WIDTH-1:0] r_p;
  logic [3:0]                        r_mode;
  logic [2*SHIFT_WIDTH-1:0]          r_shift;
  logic                              r_chan;

  logic [SHIFT_WIDTH-1:0]            w_shift;
  logic [L*OUT_WIDTH-1:0]            w_q;

  assign in_ready = (r_state == ST_IDLE);
  assign w_shift  = r_chan ? r_shift[2*SHIFT_WIDTH-1:SHIFT_WIDTH] : r_shift[SHIFT_WIDTH-1:0];

  // Lane mux ahead of a single 32-lane quantizer shared by both channels.
  for (genvar k = 0; k < L; k++) begin : g_lane
    logic [MULT_P_WIDTH-1:0] w_lo;
    logic [MULT_P_WIDTH-1:0] w_hi;
    logic [MULT_P_WIDTH-1:0] w_sel;
    logic [7:0]              w_unused_top;

    assign w_lo         = r_p[k*MULT_P_WIDTH +: MULT_P_WIDTH];
    assign w_hi         = r_p[(k+L)*MULT_P_WIDTH +: MULT_P_WIDTH];
    assign w_unused_top = w_hi[MULT_P_WIDTH-1:32];

    always_comb begin
      w_sel = w_lo;
      if (r_mode != MODE_88) begin
        if (r_chan) begin
          w_sel = {{(MULT_P_WIDTH-32){w_hi[31]}}, w_hi[31:0]};
        end else begin
          w_sel = {{(MULT_P_WIDTH-32){w_lo[31]}}, w_lo[31:0]};
        end
      end
    end

    quan_lane_round_sat u_lane (
      .i_p     (w_sel),
      .i_shift (w_shift),
      .o_q     (w_q[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_p         <= '0;
      r_mode      <= '0;
      r_shift     <= '0;
      r_chan      <= 1'b0;
      out_valid   <= 1'b0;
      out_vector  <= '0;
      out_channel <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_p     <= P_vector;
            r_mode  <= mode;
            r_shift <= shift_set;
            r_chan  <= 1'b0;
            // Unsupported modes are swallowed without producing a beat.
            if (mode == MODE_88 || mode == MODE_18) begin
              r_state <= ST_QUANT;
            end
          end
        end
        ST_QUANT: begin
          out_vector  <= w_q;
          out_channel <= r_chan;
          out_last    <= (r_mode == MODE_88) || r_chan;
          out_valid   <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_chan  <= 1'b1;
              r_state <= ST_QUANT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quan_mult_p_vecop_unpack.sv
// tb/tb_quan_mult_p_vecop_unpack.sv - self-checking bench for the product vector unpacker
module tb_quan_mult_p_vecop_unpack;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    mode;
  logic [11:0]   shift_set;
  logic [2559:0] P_vector;
  logic          out_valid;
  logic          out_ready;
  logic [255:0]  out_vector;
  logic          out_channel;
  logic          out_last;

  int n_pass  = 0;
  int n_total = 0;

  quan_mult_p_vecop_unpack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .shift_set   (shift_set),
    .P_vector    (P_vector),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vector  (out_vector),
    .out_channel (out_channel),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Reference quantizer: plain integer arithmetic on the rounding rule.
  function automatic logic [7:0] ref_q(input longint v, input int s);
    int     sc;
    longint sum;
    longint r;
    sc  = (s > 39) ? 39 : s;
    sum = v + ((sc > 0) ? (longint'(1) <<< (sc - 1)) : longint'(0));
    r   = sum >>> sc;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic logic [255:0] model_beat(input logic [2559:0] p, input logic [3:0] m,
                                              input logic [11:0] sh, input int ch);
    logic [255:0]       res;
    logic [39:0]        lane;
    logic signed [39:0] t40;
    logic signed [31:0] t32;
    longint             v;
    int                 s;
    res = '0;
    s   = (ch == 1) ? int'(sh[11:6]) : int'(sh[5:0]);
    for (int k = 0; k < 32; k++) begin
      lane = p[(ch*32 + k)*40 +: 40];
      t40  = lane;
      t32  = lane[31:0];
      v    = (m == 4'd0) ? longint'(t40) : longint'(t32);
      res[k*8 +: 8] = ref_q(v, s);
    end
    return res;
  endfunction

  function automatic logic [2559:0] rand_vector();
    logic [2559:0]      p;
    logic [63:0]        r;
    logic signed [39:0] t;
    p = '0;
    for (int k = 0; k < 64; k++) begin
      r = {$urandom, $urandom};
      t = r[39:0];
      t = t >>> $urandom_range(0, 39);
      p[k*40 +: 40] = t;
    end
    return p;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_send", {255'b0, in_ready}, 256'd1);
  endtask

  task automatic drive(input logic [3:0] m, input logic [11:0] sh, input logic [2559:0] p);
    mode      = m;
    shift_set = sh;
    P_vector  = p;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Sends one vector with out_ready high and checks every beat and its cycle timing.
  task automatic run_vector(input logic [3:0] m, input logic [11:0] sh, input logic [2559:0] p,
                            output logic [255:0] b0, output logic [255:0] b1);
    int nb;
    b0 = '0;
    b1 = '0;
    nb = (m == 4'd0) ? 1 : (m == 4'd1) ? 2 : 0;
    wait_ready();
    drive(m, sh, p);
    if (nb == 0) begin
      @(negedge clk);
      check("unsupported_no_valid", {255'b0, out_valid}, 256'd0);
      check("unsupported_ready", {255'b0, in_ready}, 256'd1);
    end
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      check("valid_low_during_quant", {255'b0, out_valid}, 256'd0);
      @(negedge clk);
      check("valid_high", {255'b0, out_valid}, 256'd1);
      check("beat_channel", {255'b0, out_channel}, 256'(b));
      check("beat_last", {255'b0, out_last}, (b == nb - 1) ? 256'd1 : 256'd0);
      check("beat_vector", out_vector, model_beat(p, m, sh, b));
      check("in_ready_busy", {255'b0, in_ready}, 256'd0);
      if (b == 0) b0 = out_vector;
      else b1 = out_vector;
      @(posedge clk);
    end
    if (nb > 0) begin
      @(negedge clk);
      check("ready_after_last", {255'b0, in_ready}, 256'd1);
      check("valid_after_last", {255'b0, out_valid}, 256'd0);
    end
  endtask

  typedef struct {
    logic [3:0]  mode;
    logic [11:0] shift;
    int          lane;
    logic [39:0] value;
    logic [7:0]  exp;
  } vec_t;

  vec_t          tbl[12];
  logic [2559:0] p;
  logic [255:0]  b0;
  logic [255:0]  b1;
  logic [255:0]  got;
  logic [3:0]    m;
  logic [11:0]   sh;
  logic [5:0]    s0;
  logic [5:0]    s1;
  int            seen;

  initial begin
    tbl[0]  = '{4'd0, 12'd4,   0,  40'd384,           8'd24};
    tbl[1]  = '{4'd0, 12'd4,   1,  40'd1000,          8'd63};
    tbl[2]  = '{4'd0, 12'd4,   2,  40'hFF_FFFF_FFF8,  8'h00};
    tbl[3]  = '{4'd0, 12'd4,   3,  40'hFF_FFFF_FFF7,  8'hFF};
    tbl[4]  = '{4'd0, 12'd0,   4,  40'hFF_FFFF_FED4,  8'h80};
    tbl[5]  = '{4'd1, 12'h001, 0,  40'hAA_FFFF_FF00,  8'h80};
    tbl[6]  = '{4'd1, 12'h001, 32, 40'd200,           8'h7F};
    tbl[7]  = '{4'd0, 12'd63,  5,  40'hFF_FFFF_FFFB,  8'h00};
    tbl[8]  = '{4'd0, 12'd63,  6,  40'h40_0000_0000,  8'h01};
    tbl[9]  = '{4'd0, 12'd63,  7,  40'h80_0000_0000,  8'hFF};
    tbl[10] = '{4'd0, 12'd5,   8,  40'h00_4000_0000,  8'h7F};
    tbl[11] = '{4'd1, 12'd128, 33, 40'hFF_0000_0009,  8'h02};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = '0;
    shift_set = '0;
    P_vector  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {255'b0, out_valid}, 256'd0);
    check("reset_out_vector", out_vector, 256'd0);
    check("reset_out_channel", {255'b0, out_channel}, 256'd0);
    check("reset_out_last", {255'b0, out_last}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {255'b0, in_ready}, 256'd1);

    for (int i = 0; i < 12; i++) begin
      p = '0;
      p[tbl[i].lane*40 +: 40] = tbl[i].value;
      run_vector(tbl[i].mode, tbl[i].shift, p, b0, b1);
      got = (tbl[i].lane >= 32) ? b1 : b0;
      check($sformatf("table_%0d_lane", i), {248'b0, got[(tbl[i].lane % 32)*8 +: 8]}, {248'b0, tbl[i].exp});
    end

    // Unsupported mode followed straight away by a normal mode-0 vector.
    run_vector(4'd3, 12'd0, rand_vector(), b0, b1);
    run_vector(4'd0, 12'd3, rand_vector(), b0, b1);

    // Backpressure on beat 0 of a mode-1 vector.
    p  = rand_vector();
    sh = {6'd2, 6'd7};
    wait_ready();
    out_ready = 1'b0;
    drive(4'd1, sh, p);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", {255'b0, out_valid}, 256'd1);
      check("bp_vector", out_vector, model_beat(p, 4'd1, sh, 0));
      check("bp_channel", {255'b0, out_channel}, 256'd0);
      check("bp_last", {255'b0, out_last}, 256'd0);
      check("bp_in_ready", {255'b0, in_ready}, 256'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_gap", {255'b0, out_valid}, 256'd0);
    @(negedge clk);
    check("bp_beat1_valid", {255'b0, out_valid}, 256'd1);
    check("bp_beat1_channel", {255'b0, out_channel}, 256'd1);
    check("bp_beat1_last", {255'b0, out_last}, 256'd1);
    check("bp_beat1_vector", out_vector, model_beat(p, 4'd1, sh, 1));
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after", {255'b0, in_ready}, 256'd1);

    // Reset while beat 0 of a mode-1 vector is held.
    p = rand_vector();
    wait_ready();
    out_ready = 1'b0;
    drive(4'd1, 12'h041, p);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_valid", {255'b0, out_valid}, 256'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", {255'b0, out_valid}, 256'd0);
    check("rst_mid_vector", out_vector, 256'd0);
    check("rst_mid_ready", {255'b0, in_ready}, 256'd1);
    check("rst_mid_channel", {255'b0, out_channel}, 256'd0);
    check("rst_mid_last", {255'b0, out_last}, 256'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_beat1", 256'(seen), 256'd0);
    run_vector(4'd0, 12'd1, rand_vector(), b0, b1);

    // Randomized vectors against the reference model.
    for (int i = 0; i < 24; i++) begin
      m  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
      s0 = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 39));
      s1 = 6'($urandom_range(0, 63));
      run_vector(m, {s1, s0}, rand_vector(), b0, b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
